// File: rtl/jam_cost_server_if.sv
// Host/engine bus for jam_cost_server: serial table load, W/J lookup, result capture.
interface jam_cost_if #(
  parameter int COST_W = 7,
  parameter int SUM_W  = 10,
  parameter int CNT_W  = 4
);
  logic              reload;
  logic              wr_en;
  logic [COST_W-1:0] wr_data;
  logic              ready;
  logic [2:0]        W;
  logic [2:0]        J;
  logic [COST_W-1:0] Cost;
  logic              Valid;
  logic [SUM_W-1:0]  MinCost;
  logic [CNT_W-1:0]  MatchCount;
  logic              done;
  logic [SUM_W-1:0]  result_min;
  logic [CNT_W-1:0]  result_cnt;
  logic [15:0]       access_cnt;

  modport master (
    output reload, wr_en, wr_data, W, J, Valid, MinCost, MatchCount,
    input  ready, Cost, done, result_min, result_cnt, access_cnt
  );

  modport slave (
    input  reload, wr_en, wr_data, W, J, Valid, MinCost, MatchCount,
    output ready, Cost, done, result_min, result_cnt, access_cnt
  );
endinterface

// File: rtl/jam_cost_server.sv
// 8x8 cost table with serial load, registered 1-cycle lookup and one-shot result capture.
// Optional lookup counter enabled by defining JAM_ACCESS_CNT_EN.
module jam_cost_server #(
  parameter int COST_W = 7,
  parameter int SUM_W  = 10,
  parameter int CNT_W  = 4
) (
  input  logic     CLK,
  input  logic     RST,
  jam_cost_if.slave bus
);

  typedef enum logic [1:0] {
    LOAD,
    SERVE,
    CAPTURE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [5:0]        wr_addr;
  logic [COST_W-1:0] cost_mem [64];
  logic              load_wr;
  logic              capture;

  // reload wins over a same-cycle write, and a result is taken only once per load
  assign load_wr = (state == LOAD) && bus.wr_en && !bus.reload;
  assign capture = (state == SERVE) && bus.Valid && !bus.done && !bus.reload;
  assign bus.ready = (state != LOAD);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (load_wr && (wr_addr == 6'd63)) state_next = SERVE;
      SERVE:   if (capture) state_next = CAPTURE;
      CAPTURE: state_next = SERVE;
      default: state_next = LOAD;
    endcase
    if (bus.reload) begin
      state_next = LOAD;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || bus.reload) begin
      wr_addr <= '0;
    end else if (load_wr) begin
      wr_addr <= (wr_addr == 6'd63) ? 6'd0 : wr_addr + 6'd1;
    end
  end

  // Table storage is deliberately unreset so it maps onto plain RAM
  always_ff @(posedge CLK) begin
    if (load_wr) begin
      cost_mem[wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || bus.reload || (state == LOAD)) begin
      bus.Cost <= '0;
    end else begin
      bus.Cost <= cost_mem[{bus.W, bus.J}];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || bus.reload) begin
      bus.done       <= 1'b0;
      bus.result_min <= '0;
      bus.result_cnt <= '0;
    end else if (capture) begin
      bus.done       <= 1'b1;
      bus.result_min <= bus.MinCost;
      bus.result_cnt <= bus.MatchCount;
    end
  end

`ifdef JAM_ACCESS_CNT_EN
  logic [15:0] access_q;

  // Counts every serving cycle and sticks at full scale
  always_ff @(posedge CLK) begin
    if (RST || bus.reload) begin
      access_q <= '0;
    end else if ((state != LOAD) && (access_q != 16'hFFFF)) begin
      access_q <= access_q + 16'd1;
    end
  end

  assign bus.access_cnt = access_q;
`else
  assign bus.access_cnt = '0;
`endif

endmodule

// File: tb/tb_jam_cost_server.sv
// Directed-vector bench for jam_cost_server; access_cnt expectations follow JAM_ACCESS_CNT_EN.
module tb_jam_cost_server;

`ifdef JAM_ACCESS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   tests_run = 0;
  int   tests_failed = 0;

  jam_cost_if bus ();

  jam_cost_server dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] w, input logic [2:0] j);
    bus.W = w;
    bus.J = j;
    tick();
  endtask

  // fill < 0 loads each entry with its own index; gapped drops wr_en every other cycle
  task automatic load_table(input int fill, input bit gapped);
    for (int i = 0; i < 64; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = (fill < 0) ? 7'(i) : 7'(fill);
      if (i == 63) bus.Valid = 1'b0;
      tick();
      bus.wr_en = 1'b0;
      if (i == 31) checkOutput("cost_in_load", 32'(bus.Cost), 0);
      if (i == 62) checkOutput("ready_before_last", 32'(bus.ready), 0);
      if (gapped && i < 63) begin
        tick();
        if (i == 40) checkOutput("cost_in_gap", 32'(bus.Cost), 0);
        if (i == 62) checkOutput("ready_in_last_gap", 32'(bus.ready), 0);
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.reload     = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_data    = '0;
    bus.W          = '0;
    bus.J          = '0;
    bus.Valid      = 1'b0;
    bus.MinCost    = '0;
    bus.MatchCount = '0;
    repeat (2) tick();
    rst = 1'b0;

    checkOutput("rst_ready", 32'(bus.ready), 0);
    checkOutput("rst_cost", 32'(bus.Cost), 0);
    checkOutput("rst_done", 32'(bus.done), 0);
    checkOutput("rst_result_min", 32'(bus.result_min), 0);
    checkOutput("rst_result_cnt", 32'(bus.result_cnt), 0);
    checkOutput("rst_access_cnt", 32'(bus.access_cnt), 0);

    bus.W = 3'd3;
    bus.J = 3'd5;
    load_table(-1, 1'b0);
    checkOutput("ready_after_load", 32'(bus.ready), 1);
    checkOutput("cost_same_edge_as_last_write", 32'(bus.Cost), 0);
    checkOutput("done_after_load", 32'(bus.done), 0);

    applyStimulus(3'd3, 3'd5);
    checkOutput("cost_w3_j5", 32'(bus.Cost), 29);
    applyStimulus(3'd7, 3'd7);
    checkOutput("cost_w7_j7", 32'(bus.Cost), 63);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(3'(k), 3'(7 - k));
      checkOutput("cost_diag", 32'(bus.Cost), 32'(7 * k + 7));
    end
    checkOutput("access_cnt_10", 32'(bus.access_cnt), CNT_EN ? 10 : 0);

    bus.W          = 3'd2;
    bus.J          = 3'd6;
    bus.MinCost    = 10'd247;
    bus.MatchCount = 4'd3;
    bus.Valid      = 1'b1;
    tick();
    bus.Valid = 1'b0;
    checkOutput("capture_done", 32'(bus.done), 1);
    checkOutput("capture_min", 32'(bus.result_min), 247);
    checkOutput("capture_cnt", 32'(bus.result_cnt), 3);
    checkOutput("cost_at_capture", 32'(bus.Cost), 22);
    applyStimulus(3'd1, 3'd1);
    checkOutput("cost_in_capture", 32'(bus.Cost), 9);

    bus.MinCost    = 10'd100;
    bus.MatchCount = 4'd9;
    bus.Valid      = 1'b1;
    tick();
    bus.Valid = 1'b0;
    tick();
    checkOutput("no_recapture_min", 32'(bus.result_min), 247);
    checkOutput("no_recapture_cnt", 32'(bus.result_cnt), 3);
    checkOutput("done_sticky", 32'(bus.done), 1);

    bus.reload  = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 7'd99;
    tick();
    bus.reload = 1'b0;
    bus.wr_en  = 1'b0;
    checkOutput("reload_ready", 32'(bus.ready), 0);
    checkOutput("reload_done", 32'(bus.done), 0);
    checkOutput("reload_result_min", 32'(bus.result_min), 0);
    checkOutput("reload_result_cnt", 32'(bus.result_cnt), 0);
    checkOutput("reload_access_cnt", 32'(bus.access_cnt), 0);
    tick();
    checkOutput("cost_after_reload", 32'(bus.Cost), 0);

    load_table(1, 1'b1);
    checkOutput("ready_after_gapped", 32'(bus.ready), 1);
    applyStimulus(3'd0, 3'd0);
    checkOutput("cost_ones_w0_j0", 32'(bus.Cost), 1);
    applyStimulus(3'd7, 3'd7);
    checkOutput("cost_ones_w7_j7", 32'(bus.Cost), 1);
    applyStimulus(3'd4, 3'd2);
    checkOutput("cost_ones_w4_j2", 32'(bus.Cost), 1);

    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 7'd50;
      tick();
    end
    bus.wr_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midload_rst_ready", 32'(bus.ready), 0);
    checkOutput("midload_rst_cost", 32'(bus.Cost), 0);
    checkOutput("midload_rst_access", 32'(bus.access_cnt), 0);

    bus.MinCost    = 10'd123;
    bus.MatchCount = 4'd7;
    bus.Valid      = 1'b1;
    load_table(5, 1'b0);
    checkOutput("fresh_load_ready", 32'(bus.ready), 1);
    checkOutput("valid_in_load_done", 32'(bus.done), 0);
    checkOutput("valid_in_load_min", 32'(bus.result_min), 0);
    for (int a = 0; a < 64; a++) begin
      applyStimulus(3'(a / 8), 3'(a % 8));
      checkOutput("cost_all_five", 32'(bus.Cost), 5);
    end
    checkOutput("done_after_fresh", 32'(bus.done), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
